// File: rtl/i_mem_loader.sv
// Instruction-memory write-side loader: takes 32-bit words on a valid/ready
// stream and writes them little-endian, one byte per cycle, holding the core stalled.
module i_mem_loader #(
  parameter int ElemWidth = 8,
  parameter int Depth     = 120,
  parameter int AW        = $clog2(Depth + 1),
  parameter int CW        = $clog2(Depth / 4 + 1),
  localparam int DPW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s_valid,
  input  logic [DPW-1:0]       s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [ElemWidth-1:0] mem_wdata,
  output logic                 cpu_stall,
  output logic                 load_done,
  output logic                 load_err,
  output logic [CW-1:0]        words_loaded
);
  localparam int Lanes = DPW / ElemWidth;
  localparam int IW    = $clog2(Lanes);

  typedef enum logic [1:0] {RECV, WRITE, DONE, ERROR} state_t;

  state_t                          state;
  logic [AW-1:0]                   addr_q;
  logic [IW-1:0]                   idx_q;
  logic [Lanes-1:0][ElemWidth-1:0] word_q;
  logic                            last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RECV;
      addr_q       <= '0;
      idx_q        <= '0;
      words_loaded <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      case (state)
        RECV: if (s_valid) begin
          // A word arriving with the memory already full is dropped, not written.
          if (addr_q == AW'(Depth)) state <= ERROR;
          else begin
            word_q <= s_data;
            last_q <= s_last;
            idx_q  <= '0;
            state  <= WRITE;
          end
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == IW'(Lanes - 1)) begin
            words_loaded <= words_loaded + 1'b1;
            state        <= last_q ? DONE : RECV;
          end
        end
        DONE, ERROR: if (start) begin
          addr_q       <= '0;
          words_loaded <= '0;
          state        <= RECV;
        end
        default: state <= RECV;
      endcase
    end
  end

  // Everything below decodes registered state only; nothing depends on s_valid.
  assign s_ready   = (state == RECV);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? word_q[idx_q] : '0;
  assign cpu_stall = (state != DONE);
  assign load_done = (state == DONE);
  assign load_err  = (state == ERROR);

endmodule

// File: tb/tb_i_mem_loader.sv
// Bench for i_mem_loader: directed scenarios plus random images on a full-size
// (Depth=120) and a tiny (Depth=8) instance, checked against a word-list model.
module tb_i_mem_loader;
  localparam int DA = 120;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       start, s_valid, s_last;
  logic [1:0][31:0] s_data;
  logic [1:0]       s_ready, mem_we, cpu_stall, load_done, load_err;
  logic [1:0][7:0]  mem_wdata;
  logic [6:0]       addr_a;
  logic [3:0]       addr_b;
  logic [4:0]       wl_a;
  logic [1:0]       wl_b;

  int n_cmp = 0;
  int n_err = 0;
  int wr_a = 0, wr_b = 0, oob = 0;
  logic [7:0] mem_a [DA];
  logic [7:0] mem_b [DB];

  always #5 clk = ~clk;

  i_mem_loader #(.Depth(DA)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .s_valid(s_valid[0]), .s_data(s_data[0]),
    .s_last(s_last[0]), .s_ready(s_ready[0]), .mem_we(mem_we[0]), .mem_addr(addr_a),
    .mem_wdata(mem_wdata[0]), .cpu_stall(cpu_stall[0]), .load_done(load_done[0]),
    .load_err(load_err[0]), .words_loaded(wl_a));

  i_mem_loader #(.Depth(DB)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .s_valid(s_valid[1]), .s_data(s_data[1]),
    .s_last(s_last[1]), .s_ready(s_ready[1]), .mem_we(mem_we[1]), .mem_addr(addr_b),
    .mem_wdata(mem_wdata[1]), .cpu_stall(cpu_stall[1]), .load_done(load_done[1]),
    .load_err(load_err[1]), .words_loaded(wl_b));

  // Byte-wide instruction memories: written on the edge while mem_we is high.
  always @(posedge clk) begin
    if (mem_we[0]) begin
      if (int'(addr_a) < DA) mem_a[addr_a] <= mem_wdata[0]; else oob <= oob + 1;
      wr_a <= wr_a + 1;
    end
    if (mem_we[1]) begin
      if (int'(addr_b) < DB) mem_b[addr_b[2:0]] <= mem_wdata[1]; else oob <= oob + 1;
      wr_b <= wr_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1; tick(1); start[u] = 1'b0;
  endtask

  task automatic send(input int u, input logic [31:0] w, input logic last);
    int t = 0;
    s_valid[u] = 1'b1; s_data[u] = w; s_last[u] = last;
    while (!s_ready[u] && t < 50) begin tick(1); t++; end
    if (t >= 50) chk("send_timeout", 1, 0);
    tick(1);
    s_valid[u] = 1'b0; s_last[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int t = 0;
    while (!load_done[u] && t < 50) begin tick(1); t++; end
    chk("wait_done", load_done[u], 1);
  endtask

  function automatic logic [31:0] word_a(input int j);
    return {mem_a[4*j+3], mem_a[4*j+2], mem_a[4*j+1], mem_a[4*j]};
  endfunction

  function automatic logic [31:0] word_b(input int j);
    return {mem_b[4*j+3], mem_b[4*j+2], mem_b[4*j+1], mem_b[4*j]};
  endfunction

  initial begin
    logic [31:0] words [$];
    int base, n, cap;
    logic [7:0] exp_bytes [8];
    logic [31:0] w;

    rst = 1'b1; start = '0; s_valid = '0; s_last = '0; s_data = '0;
    tick(2);
    chk("rst_ready", s_ready, 2'b11);
    chk("rst_we", mem_we, 2'b00);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", mem_wdata[0], 0);
    chk("rst_stall", cpu_stall, 2'b11);
    chk("rst_done_err", {load_done, load_err}, 0);
    chk("rst_words", wl_a, 0);
    rst = 1'b0;
    tick(1);

    // Two-word load, with byte-level expectations written out by hand.
    base = wr_a;
    send(0, 32'h0050_0113, 1'b0);
    chk("w1_ready_low", s_ready[0], 0);
    chk("w1_first_byte", {mem_we[0], addr_a, mem_wdata[0]}, {1'b1, 7'd0, 8'h13});
    send(0, 32'h00C0_0193, 1'b1);
    wait_done(0);
    exp_bytes = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    for (int i = 0; i < 8; i++) chk($sformatf("two_word_b%0d", i), mem_a[i], exp_bytes[i]);
    chk("two_word_writes", wr_a - base, 8);
    chk("two_word_stall", cpu_stall[0], 0);
    chk("two_word_count", wl_a, 2);

    // Reload; a second start while already receiving must change nothing.
    pulse_start(0);
    chk("reload_state", {s_ready[0], load_done[0], cpu_stall[0], wl_a}, {3'b101, 5'd0});
    pulse_start(0);
    chk("start_in_recv", {s_ready[0], addr_a}, {1'b1, 7'd0});
    send(0, 32'h0000_0013, 1'b1);
    wait_done(0);
    chk("reload_word", word_a(0), 32'h0000_0013);
    chk("reload_count", wl_a, 1);

    // Backpressure: s_valid held high through WRITE with a different word.
    pulse_start(0);
    base = wr_a;
    s_valid[0] = 1'b1; s_data[0] = 32'hDEAD_BEEF; s_last[0] = 1'b0;
    tick(1);
    s_data[0] = 32'hCAFE_F00D; s_last[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_write_c%0d", i), {s_ready[0], mem_we[0]}, 2'b01);
      tick(1);
    end
    chk("bp_back_recv", {s_ready[0], mem_we[0], wl_a}, {2'b10, 5'd1});
    tick(1);
    s_valid[0] = 1'b0; s_last[0] = 1'b0;
    wait_done(0);
    chk("bp_word0", word_a(0), 32'hDEAD_BEEF);
    chk("bp_word1", word_a(1), 32'hCAFE_F00D);
    chk("bp_writes", wr_a - base, 8);
    chk("bp_count", wl_a, 2);

    // Overflow on the Depth=8 instance: third word dropped.
    base = wr_b;
    send(1, 32'h0101_0101, 1'b0);
    send(1, 32'h0202_0202, 1'b0);
    send(1, 32'h0303_0303, 1'b0);
    chk("ovf_err", {load_err[1], cpu_stall[1], s_ready[1], load_done[1]}, 4'b1100);
    chk("ovf_count", wl_b, 2);
    chk("ovf_writes", wr_b - base, 8);
    chk("ovf_last_word", word_b(1), 32'h0202_0202);
    tick(3);
    chk("ovf_sticky", load_err[1], 1);
    pulse_start(1);
    chk("ovf_clear", {s_ready[1], addr_b, load_err[1], wl_b}, {1'b1, 4'd0, 1'b0, 2'd0});

    // Exact fill: the word ending at Depth carries last.
    send(1, 32'hA1B2_C3D4, 1'b0);
    send(1, 32'h1122_3344, 1'b1);
    wait_done(1);
    chk("fill_flags", {load_err[1], cpu_stall[1], wl_b}, {2'b00, 2'd2});
    chk("fill_word0", word_b(0), 32'hA1B2_C3D4);

    // Reset after two bytes of a word: partial bytes stay, loader restarts at 0.
    pulse_start(0);
    base = wr_a;
    send(0, 32'h1122_3344, 1'b0);
    tick(2);
    rst = 1'b1; #1;
    chk("rstw_outputs", {s_ready[0], mem_we[0], addr_a, cpu_stall[0], wl_a},
        {2'b10, 7'd0, 1'b1, 5'd0});
    chk("rstw_partial", {mem_a[1], mem_a[0]}, 16'h3344);
    chk("rstw_writes", wr_a - base, 2);
    tick(1);
    rst = 1'b0;
    send(0, 32'hA5A5_0F0F, 1'b1);
    wait_done(0);
    chk("rstw_reload", word_a(0), 32'hA5A5_0F0F);

    // Random images on the full-size instance.
    for (int r = 0; r < 3; r++) begin
      pulse_start(0);
      words.delete();
      n = $urandom_range(1, DA / 4);
      for (int j = 0; j < n; j++) words.push_back($urandom);
      base = wr_a;
      for (int j = 0; j < n; j++) begin
        tick($urandom_range(0, 3));
        send(0, words[j], j == n - 1);
      end
      wait_done(0);
      for (int j = 0; j < n; j++) begin
        w = words[j];
        chk($sformatf("rnd_a%0d_w%0d", r, j), word_a(j), w);
      end
      chk("rnd_a_count", wl_a, n);
      chk("rnd_a_writes", wr_a - base, 4 * n);
    end

    // Random images on the tiny instance: anything past two words overflows.
    cap = DB / 4;
    for (int r = 0; r < 4; r++) begin
      pulse_start(1);
      words.delete();
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) words.push_back($urandom);
      base = wr_b;
      for (int j = 0; j < n && j <= cap; j++) send(1, words[j], j == n - 1);
      if (n > cap) chk("rnd_b_err", {load_err[1], load_done[1]}, 2'b10);
      else wait_done(1);
      for (int j = 0; j < n && j < cap; j++) begin
        w = words[j];
        chk($sformatf("rnd_b%0d_w%0d", r, j), word_b(j), w);
      end
      chk("rnd_b_count", wl_b, (n > cap) ? cap : n);
      chk("rnd_b_writes", wr_b - base, 4 * ((n > cap) ? cap : n));
    end

    chk("no_out_of_range", oob, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
